mem_arbiter: RTL and testbench

//  Shares one mem_system instance between the instruction-fetch port (I) and the data port (D).

---
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch port, data port and mem_system signals of mem_arbiter.
// slave  : arbiter view (takes requests and memory responses, drives results and memory commands)
// master : surrounding view (pipeline requesters plus mem_system)
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic [ADDR_W-1:0] i_addr;
    logic              i_rd;
    logic [DATA_W-1:0] i_data_out;
    logic              i_done;
    logic              i_stall;

    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_data_in;
    logic              d_rd;
    logic              d_wr;
    logic [DATA_W-1:0] d_data_out;
    logic              d_done;
    logic              d_stall;
    logic              d_err;
    logic              d_cache_hit;

    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data_in;
    logic              m_rd;
    logic              m_wr;
    logic [DATA_W-1:0] m_data_out;
    logic              m_done;
    logic              m_cache_hit;
    logic              m_err;

    modport slave (
        input  i_addr, i_rd, d_addr, d_data_in, d_rd, d_wr,
        input  m_data_out, m_done, m_cache_hit, m_err,
        output i_data_out, i_done, i_stall,
        output d_data_out, d_done, d_stall, d_err, d_cache_hit,
        output m_addr, m_data_in, m_rd, m_wr
    );

    modport master (
        output i_addr, i_rd, d_addr, d_data_in, d_rd, d_wr,
        output m_data_out, m_done, m_cache_hit, m_err,
        input  i_data_out, i_done, i_stall,
        input  d_data_out, d_done, d_stall, d_err, d_cache_hit,
        input  m_addr, m_data_in, m_rd, m_wr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one mem_system between the fetch (I) and data (D) ports: one access at a time,
// issued as a single Rd/Wr pulse, result routed back to the granted port on m_done.
// Optional macro ROUND_ROBIN_EN: alternate grants on contention instead of fixed D
// priority with the starvation escape for I.
module mem_arbiter #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } stateT;

    stateT stateQ, stateD;
    logic  grantDQ, grantDD;   // 1: data port owns the access, 0: fetch port
    logic  opRdQ, opRdD;
    logic  opWrQ, opWrD;
`ifdef ROUND_ROBIN_EN
    logic  rrLastQ, rrLastD;   // 1: data port was granted last
`else
    logic [CNT_W-1:0] starveCntQ, starveCntD;
`endif

    logic              iReq, dReq, pickD;
    logic [ADDR_W-1:0] selAddr, mAddr;
    logic [DATA_W-1:0] selData, mDataIn, finData;
    logic              mRd, mWr, finish, finErr, finHit, iDone, dDone;

    assign iReq    = bus.i_rd;
    assign dReq    = bus.d_rd | bus.d_wr;
    assign selAddr = grantDQ ? bus.d_addr : bus.i_addr;
    assign selData = grantDQ ? bus.d_data_in : '0;

    // Winner among the currently pending requests
`ifdef ROUND_ROBIN_EN
    assign pickD = dReq & (~iReq | ~rrLastQ);
`else
    assign pickD = dReq & ~(iReq & (starveCntQ == CNT_W'(STARVE_LIMIT)));
`endif

    // State, grant and arbitration history registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ     <= IDLE;
            grantDQ    <= 1'b0;
            opRdQ      <= 1'b0;
            opWrQ      <= 1'b0;
`ifdef ROUND_ROBIN_EN
            rrLastQ    <= 1'b1;
`else
            starveCntQ <= '0;
`endif
        end else begin
            stateQ     <= stateD;
            grantDQ    <= grantDD;
            opRdQ      <= opRdD;
            opWrQ      <= opWrD;
`ifdef ROUND_ROBIN_EN
            rrLastQ    <= rrLastD;
`else
            starveCntQ <= starveCntD;
`endif
        end
    end

    // Next state, memory command and completion decode
    always_comb begin
        stateD     = stateQ;
        grantDD    = grantDQ;
        opRdD      = opRdQ;
        opWrD      = opWrQ;
`ifdef ROUND_ROBIN_EN
        rrLastD    = rrLastQ;
`else
        starveCntD = starveCntQ;
`endif
        mRd     = 1'b0;
        mWr     = 1'b0;
        mAddr   = '0;
        mDataIn = '0;
        finish  = 1'b0;
        finErr  = 1'b0;
        finHit  = 1'b0;
        finData = '0;
        case (stateQ)
            IDLE: begin
                if (iReq | dReq) begin
                    stateD  = ISSUE;
                    grantDD = pickD;
                    opRdD   = pickD ? bus.d_rd : 1'b1;
                    opWrD   = pickD ? bus.d_wr : 1'b0;
`ifdef ROUND_ROBIN_EN
                    rrLastD = pickD;
`else
                    if (!pickD) begin
                        starveCntD = '0;
                    end else if (iReq && (starveCntQ != CNT_W'(STARVE_LIMIT))) begin
                        starveCntD = starveCntQ + CNT_W'(1);
                    end
`endif
                end
            end
            ISSUE: begin
                mAddr   = selAddr;
                mDataIn = selData;
                // Simultaneous read and write never reaches memory
                if (opRdQ && opWrQ) begin
                    finish = 1'b1;
                    finErr = 1'b1;
                    stateD = IDLE;
                end else begin
                    mRd    = opRdQ;
                    mWr    = opWrQ;
                    stateD = WAIT;
                end
            end
            WAIT: begin
                mAddr   = selAddr;
                mDataIn = selData;
                if (bus.m_done) begin
                    finish  = 1'b1;
                    finErr  = bus.m_err;
                    finHit  = bus.m_cache_hit;
                    finData = bus.m_data_out;
                    stateD  = IDLE;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    // A port that dropped its request after grant gets no done pulse
    assign iDone = finish & ~grantDQ & iReq;
    assign dDone = finish & grantDQ & dReq;

    assign bus.m_rd        = mRd;
    assign bus.m_wr        = mWr;
    assign bus.m_addr      = mAddr;
    assign bus.m_data_in   = mDataIn;
    assign bus.i_done      = iDone;
    assign bus.i_data_out  = iDone ? finData : '0;
    assign bus.i_stall     = iReq & ~iDone;
    assign bus.d_done      = dDone;
    assign bus.d_data_out  = dDone ? finData : '0;
    assign bus.d_err       = dDone & finErr;
    assign bus.d_cache_hit = dDone & finHit;
    assign bus.d_stall     = dReq & ~dDone;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model, per-cycle compare,
// reactive memory model, directed scenarios followed by randomized traffic.
module tb_mem_arbiter;
    localparam int unsigned ADDR_W       = 16;
    localparam int unsigned DATA_W       = 16;
    localparam int unsigned STARVE_LIMIT = 4;
    localparam int unsigned CNT_W        = 3;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int nCmp = 0;
    int nErr = 0;
    int cycle = 0;

    // reference model: one outstanding transaction, described by its age in cycles
    bit mActive, mPortD, mRd, mWr, mLastD, expComplete;
    int mAge, mStarve;
    bit gLog[$];
    bit mdlI, mdlD, mdlWinD;

    // memory model
    int memCnt = 0;
    int memLat = 1;
    bit errOnce, memSpur, memErrRand, randOn;
    logic [15:0] memArr [logic [15:0]];
    logic [15:0] memRdData;

    // completion monitor
    bit iDoneSeen, dDoneSeen, dDoneErr;
    int iDoneCyc, dDoneCyc, iDoneCnt, dDoneCnt, mPulses, wrCnt;
    logic [15:0] iDoneData, dDoneData, wrAddr, wrData;
    bit doneLog[$];

    // compare-side temporaries
    bit cIll, cIReq, cDReq, cIDone, cDDone;
    logic [15:0] cData;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cycle);
        end
    endtask

    // model advance on each active edge from the inputs present during the ending cycle
    always @(posedge clk) begin
        cycle++;
        if (rst) begin
            mActive = 1'b0;
            mStarve = 0;
            mLastD  = 1'b1;
        end else if (mActive) begin
            if (expComplete) mActive = 1'b0;
            else mAge++;
        end else if (bus.i_rd || bus.d_rd || bus.d_wr) begin
            mdlI = bus.i_rd;
            mdlD = bus.d_rd || bus.d_wr;
`ifdef ROUND_ROBIN_EN
            mdlWinD = mdlD && !(mdlI && mLastD);
`else
            mdlWinD = mdlD && !(mdlI && (mStarve == int'(STARVE_LIMIT)));
            if (!mdlWinD) mStarve = 0;
            else if (mdlI && mStarve < int'(STARVE_LIMIT)) mStarve++;
`endif
            mLastD  = mdlWinD;
            mPortD  = mdlWinD;
            mRd     = mdlWinD ? bus.d_rd : 1'b1;
            mWr     = mdlWinD ? bus.d_wr : 1'b0;
            mAge    = 0;
            mActive = 1'b1;
            gLog.push_back(mdlWinD);
        end
        expComplete = 1'b0;
    end

    // per-cycle compare, completion monitor and memory command capture
    always @(negedge clk) begin
        cIll  = mRd && mWr;
        expComplete = mActive && ((mAge == 0 && cIll) || (mAge > 0 && bus.m_done));
        cIReq  = bus.i_rd;
        cDReq  = bus.d_rd || bus.d_wr;
        cIDone = expComplete && !mPortD && cIReq;
        cDDone = expComplete && mPortD && cDReq;
        cData  = cIll ? 16'h0000 : bus.m_data_out;
        chk("m_rd", 32'(bus.m_rd), 32'(mActive && mAge == 0 && mRd && !cIll));
        chk("m_wr", 32'(bus.m_wr), 32'(mActive && mAge == 0 && mWr && !cIll));
        chk("m_addr", 32'(bus.m_addr), mActive ? 32'(mPortD ? bus.d_addr : bus.i_addr) : 32'd0);
        chk("m_data_in", 32'(bus.m_data_in), (mActive && mPortD) ? 32'(bus.d_data_in) : 32'd0);
        chk("i_done", 32'(bus.i_done), 32'(cIDone));
        chk("i_data_out", 32'(bus.i_data_out), cIDone ? 32'(cData) : 32'd0);
        chk("i_stall", 32'(bus.i_stall), 32'(cIReq && !cIDone));
        chk("d_done", 32'(bus.d_done), 32'(cDDone));
        chk("d_data_out", 32'(bus.d_data_out), cDDone ? 32'(cData) : 32'd0);
        chk("d_err", 32'(bus.d_err), 32'(cDDone && (cIll || bus.m_err)));
        chk("d_cache_hit", 32'(bus.d_cache_hit), 32'(cDDone && !cIll && bus.m_cache_hit));
        chk("d_stall", 32'(bus.d_stall), 32'(cDReq && !cDDone));

        if (bus.i_done) begin
            iDoneSeen = 1'b1; iDoneCyc = cycle; iDoneData = bus.i_data_out; iDoneCnt++;
            doneLog.push_back(1'b0);
        end
        if (bus.d_done) begin
            dDoneSeen = 1'b1; dDoneCyc = cycle; dDoneData = bus.d_data_out; dDoneErr = bus.d_err;
            dDoneCnt++;
            doneLog.push_back(1'b1);
        end
        if (bus.m_rd || bus.m_wr) begin
            mPulses++;
            memCnt = (memLat > 0) ? memLat : int'($urandom_range(1, 6));
            if (bus.m_wr) begin
                memArr[bus.m_addr] = bus.m_data_in;
                wrCnt++; wrAddr = bus.m_addr; wrData = bus.m_data_in;
            end
            memRdData = memArr.exists(bus.m_addr) ? memArr[bus.m_addr] : (bus.m_addr ^ 16'h5A5A);
        end
    end

    // advance one cycle: memory response, then random requesters when enabled
    task automatic tick();
        @(posedge clk);
        #1;
        bus.m_done      = 1'b0;
        bus.m_err       = 1'b0;
        bus.m_cache_hit = 1'($urandom);
        bus.m_data_out  = 16'($urandom);
        if (rst) begin
            memCnt = 0;
        end else if (memCnt > 0) begin
            memCnt--;
            if (memCnt == 0) begin
                bus.m_done     = 1'b1;
                bus.m_data_out = memRdData;
                bus.m_err      = errOnce || (memErrRand && ($urandom % 8 == 0));
                errOnce        = 1'b0;
            end
        end else if (memSpur && ($urandom % 12 == 0)) begin
            bus.m_done = 1'b1;
            bus.m_err  = 1'($urandom);
        end
        if (randOn) begin
            if (iDoneSeen) begin
                bus.i_rd = 1'b0; iDoneSeen = 1'b0;
            end else if (bus.i_rd) begin
                if ($urandom % 50 == 0) bus.i_rd = 1'b0;
            end else if (!(mActive && !mPortD) && ($urandom % 3 == 0)) begin
                bus.i_rd = 1'b1; bus.i_addr = 16'($urandom_range(0, 15));
            end
            if (dDoneSeen) begin
                bus.d_rd = 1'b0; bus.d_wr = 1'b0; dDoneSeen = 1'b0;
            end else if (bus.d_rd || bus.d_wr) begin
                if ($urandom % 50 == 0) begin bus.d_rd = 1'b0; bus.d_wr = 1'b0; end
            end else if (!(mActive && mPortD) && ($urandom % 3 == 0)) begin
                case ($urandom % 12)
                    0:              begin bus.d_rd = 1'b1; bus.d_wr = 1'b1; end
                    1, 2, 3, 4, 5:  begin bus.d_rd = 1'b1; bus.d_wr = 1'b0; end
                    default:        begin bus.d_rd = 1'b0; bus.d_wr = 1'b1; end
                endcase
                bus.d_addr    = 16'($urandom_range(0, 15));
                bus.d_data_in = 16'($urandom);
            end
        end
    endtask

    task automatic waitDone(input bit portD, input int maxC, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < maxC && !ok; k++) begin
            tick();
            @(negedge clk);
            #1;
            ok = portD ? dDoneSeen : iDoneSeen;
        end
        if (!ok) begin
            nCmp++;
            nErr++;
            $display("FAIL wait_done_%s: no done within %0d cycles", portD ? "d" : "i", maxC);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        bus.i_rd = 1'b0; bus.d_rd = 1'b0; bus.d_wr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    bit ok;
    int reqC, cnt0, wr0;
    bit expOrder [10];

    initial begin
        rst = 1'b1;
        bus.i_rd = 1'b0; bus.i_addr = '0;
        bus.d_rd = 1'b0; bus.d_wr = 1'b0; bus.d_addr = '0; bus.d_data_in = '0;
        bus.m_done = 1'b0; bus.m_err = 1'b0; bus.m_cache_hit = 1'b0; bus.m_data_out = '0;
        doReset();

        // fetch read, memory answers 5 cycles after the Rd pulse
        memArr[16'h0040] = 16'h1234;
        memLat = 5;
        cnt0 = dDoneCnt;
        tick();
        bus.i_rd = 1'b1; bus.i_addr = 16'h0040; reqC = cycle; iDoneSeen = 1'b0;
        waitDone(1'b0, 20, ok);
        if (ok) begin
            chk("t1_latency", 32'(iDoneCyc - reqC), 32'd6);
            chk("t1_data", 32'(iDoneData), 32'h1234);
        end
        chk("t1_no_d_done", 32'(dDoneCnt - cnt0), 32'd0);
        tick();
        bus.i_rd = 1'b0; iDoneSeen = 1'b0;

        // data write
        memLat = 3;
        wr0 = wrCnt;
        tick();
        bus.d_wr = 1'b1; bus.d_addr = 16'h0102; bus.d_data_in = 16'hBEEF;
        reqC = cycle; dDoneSeen = 1'b0;
        waitDone(1'b1, 20, ok);
        if (ok) begin
            chk("t2_latency", 32'(dDoneCyc - reqC), 32'd4);
            chk("t2_err", 32'(dDoneErr), 32'd0);
        end
        chk("t2_wr_pulses", 32'(wrCnt - wr0), 32'd1);
        chk("t2_wr_addr", 32'(wrAddr), 32'h0102);
        chk("t2_wr_data", 32'(wrData), 32'hBEEF);
        tick();
        bus.d_wr = 1'b0; dDoneSeen = 1'b0;

        // simultaneous read and write on the data port
        cnt0 = mPulses;
        tick();
        bus.d_rd = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 16'h0104;
        reqC = cycle; dDoneSeen = 1'b0;
        waitDone(1'b1, 10, ok);
        if (ok) begin
            chk("t4_latency", 32'(dDoneCyc - reqC), 32'd1);
            chk("t4_err", 32'(dDoneErr), 32'd1);
            chk("t4_data", 32'(dDoneData), 32'd0);
        end
        tick();
        bus.d_rd = 1'b0; bus.d_wr = 1'b0; dDoneSeen = 1'b0;
        repeat (3) tick();
        chk("t4_no_mem_pulse", 32'(mPulses - cnt0), 32'd0);

        // memory error on a data read, then a clean fetch
        memLat = 2;
        tick();
        errOnce = 1'b1;
        bus.d_rd = 1'b1; bus.d_addr = 16'h0200; dDoneSeen = 1'b0;
        waitDone(1'b1, 10, ok);
        if (ok) chk("t6_err", 32'(dDoneErr), 32'd1);
        tick();
        bus.d_rd = 1'b0; dDoneSeen = 1'b0;
        tick();
        bus.i_rd = 1'b1; bus.i_addr = 16'h0300; iDoneSeen = 1'b0;
        waitDone(1'b0, 10, ok);
        if (ok) chk("t6_i_data", 32'(iDoneData), 32'h595A);
        tick();
        bus.i_rd = 1'b0; iDoneSeen = 1'b0;

        // both ports held continuously: grant order
        doReset();
        memLat = 1;
        doneLog.delete();
        gLog.delete();
        tick();
        bus.i_rd = 1'b1; bus.i_addr = 16'h0010;
        bus.d_rd = 1'b1; bus.d_addr = 16'h0020;
        for (int k = 0; k < 300 && doneLog.size() < 10; k++) tick();
        bus.i_rd = 1'b0; bus.d_rd = 1'b0;
`ifdef ROUND_ROBIN_EN
        expOrder = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        expOrder = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
        chk("t3_done_count", 32'(doneLog.size() >= 10), 32'd1);
        for (int k = 0; k < 10; k++) begin
            if (k < doneLog.size()) chk($sformatf("t3_dut_order_%0d", k), 32'(doneLog[k]), 32'(expOrder[k]));
            if (k < gLog.size())    chk($sformatf("t3_model_order_%0d", k), 32'(gLog[k]), 32'(expOrder[k]));
        end
        repeat (10) tick();
        iDoneSeen = 1'b0; dDoneSeen = 1'b0;

        // reset while waiting on memory
        memLat = 5;
        cnt0 = iDoneCnt;
        tick();
        bus.i_rd = 1'b1; bus.i_addr = 16'h0044;
        tick();
        tick();
        rst = 1'b1; bus.i_rd = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("t5_m_rd", 32'(bus.m_rd), 32'd0);
        chk("t5_m_addr", 32'(bus.m_addr), 32'd0);
        chk("t5_m_data_in", 32'(bus.m_data_in), 32'd0);
        chk("t5_i_done", 32'(bus.i_done), 32'd0);
        chk("t5_i_stall", 32'(bus.i_stall), 32'd0);
        chk("t5_i_data_out", 32'(bus.i_data_out), 32'd0);
        chk("t5_d_done", 32'(bus.d_done), 32'd0);
        repeat (8) tick();
        chk("t5_no_done", 32'(iDoneCnt - cnt0), 32'd0);
        tick();
        bus.i_rd = 1'b1; bus.i_addr = 16'h0046; reqC = cycle; iDoneSeen = 1'b0;
        waitDone(1'b0, 20, ok);
        if (ok) begin
            chk("t5_latency", 32'(iDoneCyc - reqC), 32'd6);
            chk("t5_data", 32'(iDoneData), 32'h5A1C);
        end
        tick();
        bus.i_rd = 1'b0; iDoneSeen = 1'b0;
        tick();

        // randomized traffic against the model
        iDoneSeen = 1'b0; dDoneSeen = 1'b0;
        memLat = 0; memSpur = 1'b1; memErrRand = 1'b1; randOn = 1'b1;
        repeat (4000) tick();
        randOn = 1'b0; memSpur = 1'b0;
        bus.i_rd = 1'b0; bus.d_rd = 1'b0; bus.d_wr = 1'b0;
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
